// File: rtl/hack_wb_stage.sv
// Hack CPU writeback/sequencing stage: updates A/D, flags and PC, and issues M writes via req/ack.
// Optional retired-instruction counter enabled by defining HACK_WB_RETIRE_CNT_EN.
module hack_wb_stage #(
   parameter int PC_W   = 15,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instr,
   input  logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] a_reg,
   output logic [DATA_W-1:0] d_reg,
   output logic [PC_W-1:0]   pc,
   output logic              zr,
   output logic              ng,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack
`ifdef HACK_WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       retired
`endif
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_MEM_WAIT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] d_q, d_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              zr_q, zr_d;
   logic              ng_q, ng_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic accept;
   logic zr_now, ng_now, jmp;
   logic retire;

   assign in_ready = (state_q == S_IDLE);
   assign accept   = in_valid & in_ready;

   // Jump decision uses this instruction's ALU result, not the registered flags.
   assign zr_now = (alu_out == '0);
   assign ng_now = alu_out[DATA_W-1];
   assign jmp    = (instr[2] & ng_now) | (instr[1] & zr_now) | (instr[0] & ~ng_now & ~zr_now);

   assign retire = (accept & (~instr[15] | ~instr[3])) |
                   ((state_q == S_MEM_WAIT) & mem_ack);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      pc_d    = pc_q;
      zr_d    = zr_q;
      ng_d    = ng_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!instr[15]) begin
                  a_d  = DATA_W'(instr[14:0]);
                  pc_d = pc_q + 1'b1;
               end else begin
                  zr_d = zr_now;
                  ng_d = ng_now;
                  pc_d = jmp ? a_q[PC_W-1:0] : pc_q + 1'b1;
                  if (instr[5]) a_d = alu_out;
                  if (instr[4]) d_d = alu_out;
                  if (instr[3]) begin
                     addr_d  = a_q;
                     wdata_d = alu_out;
                     we_d    = 1'b1;
                     state_d = S_MEM_WAIT;
                  end
               end
            end
         end
         S_MEM_WAIT: begin
            if (mem_ack) begin
               we_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            we_d    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         d_q     <= '0;
         pc_q    <= '0;
         zr_q    <= 1'b0;
         ng_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         pc_q    <= pc_d;
         zr_q    <= zr_d;
         ng_q    <= ng_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign a_reg     = a_q;
   assign d_reg     = d_q;
   assign pc        = pc_q;
   assign zr        = zr_q;
   assign ng        = ng_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

`ifdef HACK_WB_RETIRE_CNT_EN
   logic [31:0] ret_q, ret_d;

   assign ret_d = retire ? ret_q + 32'd1 : ret_q;

   always_ff @(posedge clk) begin
      if (!rst_n) ret_q <= '0;
      else        ret_q <= ret_d;
   end

   assign retired = ret_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_hack_wb_stage.sv
// Directed self-checking bench for hack_wb_stage; covers the retired counter when HACK_WB_RETIRE_CNT_EN is defined.
module tb_hack_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instr;
   logic [15:0] alu_out;
   logic [15:0] a_reg, d_reg;
   logic [14:0] pc;
   logic        zr, ng;
   logic        mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack;
`ifdef HACK_WB_RETIRE_CNT_EN
   logic [31:0] retired;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   hack_wb_stage #(.PC_W(15), .DATA_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .alu_out   (alu_out),
      .a_reg     (a_reg),
      .d_reg     (d_reg),
      .pc        (pc),
      .zr        (zr),
      .ng        (ng),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack)
`ifdef HACK_WB_RETIRE_CNT_EN
      ,
      .retired   (retired)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction for a single edge, then sample 1ns after it.
   task automatic issue(input logic [15:0] ins, input logic [15:0] alu);
      in_valid = 1'b1;
      instr    = ins;
      alu_out  = alu;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_state(input string tag);
      check({tag, ".a"},     32'(a_reg),     32'h0);
      check({tag, ".d"},     32'(d_reg),     32'h0);
      check({tag, ".pc"},    32'(pc),        32'h0);
      check({tag, ".zr"},    32'(zr),        32'h0);
      check({tag, ".ng"},    32'(ng),        32'h0);
      check({tag, ".we"},    32'(mem_we),    32'h0);
      check({tag, ".addr"},  32'(mem_addr),  32'h0);
      check({tag, ".wdata"}, 32'(mem_wdata), 32'h0);
      check({tag, ".rdy"},   32'(in_ready),  32'h1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      instr    = '0;
      alu_out  = '0;
      mem_ack  = 1'b0;
      tick();
      tick();
      check_zero_state("reset");
      rst_n = 1'b1;

      // A-instruction
      issue(16'h0123, 16'hFFFF);
      check("a_instr.a",   32'(a_reg),    32'h0123);
      check("a_instr.pc",  32'(pc),       32'h1);
      check("a_instr.rdy", 32'(in_ready), 32'h1);
      check("a_instr.zr",  32'(zr),       32'h0);
      check("a_instr.ng",  32'(ng),       32'h0);

      // C: D=alu, no jump, negative result
      issue(16'hE010, 16'h8000);
      check("c_d.d",  32'(d_reg), 32'h8000);
      check("c_d.ng", 32'(ng),    32'h1);
      check("c_d.zr", 32'(zr),    32'h0);
      check("c_d.pc", 32'(pc),    32'h2);
      check("c_d.a",  32'(a_reg), 32'h0123);

      // AM= writes memory at the previous A
      issue(16'h0040, 16'h0000);
      check("a40.pc", 32'(pc), 32'h3);
      issue(16'hE028, 16'h0007);
      check("am.a",     32'(a_reg),     32'h0007);
      check("am.we",    32'(mem_we),    32'h1);
      check("am.addr",  32'(mem_addr),  32'h0040);
      check("am.wdata", 32'(mem_wdata), 32'h0007);
      check("am.rdy",   32'(in_ready),  32'h0);
      check("am.pc",    32'(pc),        32'h4);
      check("am.d",     32'(d_reg),     32'h8000);

      // Upstream holds a valid A-instr while the write is pending: must be ignored
      in_valid = 1'b1;
      instr    = 16'h1111;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         check("wait.we",    32'(mem_we),    32'h1);
         check("wait.addr",  32'(mem_addr),  32'h0040);
         check("wait.wdata", 32'(mem_wdata), 32'h0007);
         check("wait.rdy",   32'(in_ready),  32'h0);
         check("wait.a",     32'(a_reg),     32'h0007);
         check("wait.pc",    32'(pc),        32'h4);
      end
      mem_ack = 1'b1;
      tick();
      in_valid = 1'b0;
      check("ack.we",  32'(mem_we),   32'h0);
      check("ack.rdy", 32'(in_ready), 32'h1);
      check("ack.a",   32'(a_reg),    32'h0007);
      // ack while idle is ignored
      tick();
      mem_ack = 1'b0;
      check("idle_ack.we",  32'(mem_we),   32'h0);
      check("idle_ack.rdy", 32'(in_ready), 32'h1);
      check("idle_ack.pc",  32'(pc),       32'h4);

      // Jumps
      issue(16'h0010, 16'h0000);
      check("a10.pc", 32'(pc), 32'h5);
      issue(16'hE002, 16'h0000);
      check("jeq_taken.pc", 32'(pc), 32'h0010);
      check("jeq_taken.zr", 32'(zr), 32'h1);
      issue(16'hE002, 16'h0001);
      check("jeq_not.pc", 32'(pc), 32'h0011);
      check("jeq_not.zr", 32'(zr), 32'h0);
      issue(16'hE007, 16'h0005);
      check("jmp.pc", 32'(pc), 32'h0010);
      issue(16'hE000, 16'h0000);
      check("null.pc", 32'(pc), 32'h0011);
      check("null.a",  32'(a_reg), 32'h0010);
      issue(16'hE004, 16'hFFFE);
      check("jlt.pc", 32'(pc), 32'h0010);
      check("jlt.ng", 32'(ng), 32'h1);

      // PC wrap
      issue(16'h7FFF, 16'h0000);
      check("a7fff.pc", 32'(pc), 32'h0011);
      issue(16'hE007, 16'h0000);
      check("to_max.pc", 32'(pc), 32'h7FFF);
      issue(16'h0000, 16'h0000);
      check("wrap.pc", 32'(pc), 32'h0);
      check("wrap.a",  32'(a_reg), 32'h0);

      // Reset during MEM_WAIT
      issue(16'h0055, 16'h0000);
      issue(16'hE018, 16'h1234);
      check("dm.d",     32'(d_reg),     32'h1234);
      check("dm.we",    32'(mem_we),    32'h1);
      check("dm.addr",  32'(mem_addr),  32'h0055);
      check("dm.wdata", 32'(mem_wdata), 32'h1234);
      rst_n = 1'b0;
      tick();
      check_zero_state("rst_wait");
      rst_n = 1'b1;

`ifdef HACK_WB_RETIRE_CNT_EN
      check("ret.reset", retired, 32'd0);
      issue(16'h0020, 16'h0000);
      check("ret.a", retired, 32'd1);
      issue(16'hE010, 16'h0003);
      check("ret.c", retired, 32'd2);
      issue(16'hE008, 16'h0009);
      check("ret.cm",    retired,         32'd2);
      check("ret.cm_we", 32'(mem_we),     32'h1);
      check("ret.addr",  32'(mem_addr),   32'h0020);
      tick();
      check("ret.wait1", retired, 32'd2);
      tick();
      check("ret.wait2", retired, 32'd2);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("ret.ack",    retired,        32'd3);
      check("ret.ack_we", 32'(mem_we),    32'h0);
      tick();
      check("ret.idle", retired, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
